// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, controller
// transfer modes, FSM state encoding and the funct3-to-mode decode.
// Ports: none (package).
package lsu_pkg;

   // RV32 load/store funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // memory controller transfer modes
   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_BYTE = 2'b01;
   localparam logic [1:0] MODE_HALF = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_t;

   // Only funct3[1:0] selects the width; 011 and the unused upper codes fall
   // back to word, and the sign bit funct3[2] is irrelevant to the transfer.
   function automatic logic [1:0] funct3_to_mode(input logic [1:0] size);
      case (size)
         2'b00:   return MODE_BYTE;
         2'b01:   return MODE_HALF;
         default: return MODE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshake bundles of the load/store unit.
// lsu_req_if: core request/response (master = core, slave = LSU).
// lsu_mem_if: memory controller command/ready (master = LSU, slave = controller).
interface lsu_req_if #(parameter int ADDR_W = 24);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_timeout;
   logic              resp_err;

   modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                   input  req_ready, resp_valid, resp_rdata, resp_timeout, resp_err);
   modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                   output req_ready, resp_valid, resp_rdata, resp_timeout, resp_err);
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 24);
   logic              enable;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [31:0]       wdata;
   logic [1:0]        instr_mode;
   logic [31:0]       data_out;
   logic              op_r;

   modport master (output enable, addr, we, wdata, instr_mode,
                   input  data_out, op_r);
   modport slave  (input  enable, addr, we, wdata, instr_mode,
                   output data_out, op_r);
endinterface

// File: rtl/load_store_unit_extend.sv
// load_extend: RV32 sign/zero extension of raw controller read data.
// Latency: combinational. Backpressure: none.
// Ports: funct3 (load type), raw (controller data), ext (extended word).
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (funct3)
         F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
         F3_LBU:  ext = {24'd0, raw[7:0]};
         F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
         F3_LHU:  ext = {16'd0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: issues RV32 loads/stores to the memory controller and returns extended data.
// Latency: response 6 edges after accept with the current controller; watchdog ends WAIT after TIMEOUT_CYCLES.
// Backpressure: req_ready only in IDLE; one transaction in flight. Option macro: LSU_MISALIGN_TRAP_EN.
// Ports: clk, rst (sync, active-high), core (lsu_req_if.slave), mem (lsu_mem_if.master).
module load_store_unit #(
   parameter int ADDR_W         = 24,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic       clk,
   input logic       rst,
   lsu_req_if.slave  core,
   lsu_mem_if.master mem
);
   import lsu_pkg::*;

   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t        state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [2:0]        funct3_q;
   logic [1:0]        mode_q;
   logic [WD_W-1:0]   wd;
   logic [31:0]       rdata_q;
   logic              timeout_q;
   logic [31:0]       ext_data;
   logic              accept, ready, valid, enable;
   logic              misalign;

`ifdef LSU_MISALIGN_TRAP_EN
   logic       err_q;
   logic [1:0] req_mode;
   assign req_mode = funct3_to_mode(core.req_funct3[1:0]);
   assign misalign = ((req_mode == MODE_HALF) && core.req_addr[0]) ||
                     ((req_mode == MODE_WORD) && (core.req_addr[1:0] != 2'b00));
   assign core.resp_err = err_q;
`else
   assign misalign      = 1'b0;
   assign core.resp_err = 1'b0;
`endif

   load_extend u_ext (
      .funct3 (funct3_q),
      .raw    (mem.data_out),
      .ext    (ext_data)
   );

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid     = 1'b0;
      enable    = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (core.req_valid) begin
               accept    = 1'b1;
               state_nxt = misalign ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            enable    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (mem.op_r || (wd == WD_LAST)) state_nxt = RESP;
         end
         RESP: begin
            valid     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= 32'd0;
         funct3_q  <= 3'd0;
         mode_q    <= MODE_WORD;
         wd        <= '0;
         rdata_q   <= 32'd0;
         timeout_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         // qualifiers are only ever high during the single RESP cycle
         timeout_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q     <= 1'b0;
`endif
         if (accept) begin
            addr_q   <= core.req_addr;
            we_q     <= core.req_we;
            wdata_q  <= core.req_wdata;
            funct3_q <= core.req_funct3;
            mode_q   <= funct3_to_mode(core.req_funct3[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign) begin
               err_q   <= 1'b1;
               rdata_q <= 32'd0;
            end
`endif
         end
         if (state == ISSUE) wd <= '0;
         if (state == WAIT) begin
            // a ready pulse on the expiry cycle still counts as an answer
            if (mem.op_r) begin
               rdata_q <= we_q ? 32'd0 : ext_data;
            end else if (wd == WD_LAST) begin
               timeout_q <= 1'b1;
               rdata_q   <= 32'd0;
            end else if (wd != '1) begin
               wd <= wd + 1'b1;
            end
         end
      end
   end

   assign core.req_ready    = ready;
   assign core.resp_valid   = valid;
   assign core.resp_rdata   = rdata_q;
   assign core.resp_timeout = timeout_q;
   assign mem.enable        = enable;
   assign mem.addr          = addr_q;
   assign mem.we            = we_q;
   assign mem.wdata         = wdata_q;
   assign mem.instr_mode    = mode_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: controller stub with a byte memory,
// a transaction-level reference model and a per-cycle compare process.
module tb_load_store_unit;
   localparam int ADDR_W = 24;
   localparam int TO     = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_req_if #(.ADDR_W(ADDR_W)) core ();
   lsu_mem_if #(.ADDR_W(ADDR_W)) mem ();

   load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .core (core),
      .mem  (mem)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit checking = 0;
   bit stub_mute = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
   endtask

   function automatic logic [7:0] init_byte(input int i);
      case (i)
         16: return 8'haa;
         17: return 8'hbb;
         18: return 8'hcc;
         19: return 8'hdd;
         default: return 8'(i * 37 + 11);
      endcase
   endfunction

   // ---------------- controller stub: answers 4 edges after seeing enable
   logic [7:0]        smem [256];
   bit                s_init = 0;
   bit                spend = 0;
   int                scnt = 0;
   logic [ADDR_W-1:0] sa;
   logic              swe;
   logic [31:0]       swd;
   logic [1:0]        smode;
   int                s_n;
   logic [31:0]       s_rd;

   always @(posedge clk) begin
      mem.op_r <= 1'b0;
      if (!s_init) begin
         for (int i = 0; i < 256; i++) smem[i] <= init_byte(i);
         mem.data_out <= 32'd0;
         s_init <= 1;
      end
      if (mem.enable) begin
         spend <= 1; scnt <= 3;
         sa <= mem.addr; swe <= mem.we; swd <= mem.wdata; smode <= mem.instr_mode;
      end else if (spend) begin
         if (scnt > 0) scnt <= scnt - 1;
         else begin
            spend <= 0;
            if (!stub_mute) begin
               s_n  = (smode == 2'b01) ? 1 : (smode == 2'b10) ? 2 : 4;
               s_rd = 32'd0;
               for (int i = 0; i < s_n; i++) begin
                  s_rd[8*i +: 8] = smem[(int'(sa) + i) % 256];
                  if (swe) smem[(int'(sa) + i) % 256] <= swd[8*i +: 8];
               end
               mem.op_r     <= 1'b1;
               mem.data_out <= s_rd;
            end
         end
      end
   end

   // ---------------- reference model (transaction level, cycle-stamped)
   logic [7:0]        mm [256];
   bit                m_init = 0;
   int                free_at = 1 << 30;
   int                exp_resp = -1;
   int                exp_en = -1;
   int                acc_cyc = 0;
   int                n_acc = 0;
   logic [31:0]       exp_rdata = 0, prev_rdata = 0, exp_wdata = 0;
   logic              exp_timeout = 0, exp_err = 0, exp_we = 0;
   logic [ADDR_W-1:0] exp_addr = 0;
   logic [1:0]        exp_mode = 0;

   always @(posedge clk) begin
      int     nb, idx;
      bit     trap;
      longint v;
      logic [2:0]  f3;
      logic [31:0] wd;
      if (!m_init) begin
         for (int i = 0; i < 256; i++) mm[i] = init_byte(i);
         m_init = 1;
      end
      cyc++;
      if (rst) begin
         free_at = cyc; exp_resp = -1; exp_en = -1;
         prev_rdata = 0; exp_rdata = 0; exp_timeout = 0; exp_err = 0;
      end else if (core.req_valid && (cyc - 1) >= free_at) begin
         f3 = core.req_funct3;
         wd = core.req_wdata;
         nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         trap = 0;
`ifdef LSU_MISALIGN_TRAP_EN
         trap = (int'(core.req_addr) % nb) != 0;
`endif
         prev_rdata = exp_rdata;
         acc_cyc = cyc;
         n_acc++;
         exp_addr  = core.req_addr;
         exp_we    = core.req_we;
         exp_wdata = wd;
         exp_mode  = (nb == 1) ? 2'b01 : (nb == 2) ? 2'b10 : 2'b00;
         exp_timeout = 0;
         exp_err     = 0;
         exp_rdata   = 0;
         if (trap) begin
            exp_resp = cyc; exp_en = -1; exp_err = 1;
         end else begin
            exp_en = cyc;
            if (stub_mute) begin
               exp_resp = cyc + TO + 1; exp_timeout = 1;
            end else begin
               exp_resp = cyc + 6;
               v = 0;
               for (int i = 0; i < nb; i++) begin
                  idx = (int'(core.req_addr) + i) % 256;
                  if (core.req_we) mm[idx] = wd[8*i +: 8];
                  else v = v + (longint'(mm[idx]) << (8 * i));
               end
               if (f3 == 3'b000 && v >= 128)   v = v - 256;
               if (f3 == 3'b001 && v >= 32768) v = v - 65536;
               if (!core.req_we) exp_rdata = v[31:0];
            end
         end
         free_at = exp_resp + 1;
      end
   end

   // ---------------- per-cycle compare
   int          en_count = 0, resp_count = 0, got_resp_cyc = 0;
   logic [31:0] got_rdata = 0;
   logic        got_timeout = 0, got_err = 0;
   logic [ADDR_W-1:0] got_addr = 0;

   always @(negedge clk) begin
      if (checking) begin
         chk("req_ready", 32'(core.req_ready), 32'(cyc >= free_at));
         chk("resp_valid", 32'(core.resp_valid), 32'(cyc == exp_resp));
         chk("mem_enable", 32'(mem.enable), 32'(cyc == exp_en));
         chk("resp_rdata", core.resp_rdata,
             (exp_resp >= 0 && cyc >= exp_resp) ? exp_rdata : prev_rdata);
         if (cyc == exp_resp) begin
            chk("resp_timeout", 32'(core.resp_timeout), 32'(exp_timeout));
            chk("resp_err", 32'(core.resp_err), 32'(exp_err));
         end
         if (cyc == exp_en) begin
            chk("mem_addr", 32'(mem.addr), 32'(exp_addr));
            chk("mem_we", 32'(mem.we), 32'(exp_we));
            chk("mem_wdata", mem.wdata, exp_wdata);
            chk("mem_mode", 32'(mem.instr_mode), 32'(exp_mode));
         end
         if (core.resp_valid) begin
            resp_count++;
            got_rdata = core.resp_rdata; got_timeout = core.resp_timeout;
            got_err = core.resp_err; got_resp_cyc = cyc;
         end
         if (mem.enable) begin
            en_count++;
            got_addr = mem.addr;
         end
      end
   end

   // ---------------- stimulus
   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (cyc > exp_resp) break;
         @(negedge clk);
      end
      chk("txn_done", 32'(cyc > exp_resp), 32'd1);
   endtask

   task automatic do_req(input bit we, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
      int n0;
      @(negedge clk);
      core.req_valid = 1; core.req_we = we; core.req_funct3 = f3;
      core.req_addr = a; core.req_wdata = wd;
      n0 = n_acc;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (n_acc != n0) break;
      end
      core.req_valid = 0;
      chk("accepted", 32'(n_acc - n0), 32'd1);
      wait_done();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_mem_addr"}, 32'(mem.addr), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem.we), 32'd0);
      chk({tag, "_mem_wdata"}, mem.wdata, 32'd0);
      chk({tag, "_mem_mode"}, 32'(mem.instr_mode), 32'd0);
      chk({tag, "_rdata"}, core.resp_rdata, 32'd0);
      chk({tag, "_ready"}, 32'(core.req_ready), 32'd1);
      chk({tag, "_valid"}, 32'(core.resp_valid), 32'd0);
      chk({tag, "_enable"}, 32'(mem.enable), 32'd0);
   endtask

   logic [2:0]  t_f3  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
   logic [31:0] t_exp [5] = '{32'hddccbbaa, 32'hffffffaa, 32'h000000aa, 32'hffffbbaa, 32'h0000bbaa};

   initial begin
      int e0, r0, n0;
      core.req_valid = 0; core.req_we = 0; core.req_funct3 = 0;
      core.req_addr = 0; core.req_wdata = 0;
      rst = 1;
      repeat (3) @(negedge clk);
      checking = 1;
      rst = 0;
      chk_reset_state("reset");

      // loads of the preloaded word at 0x10
      for (int i = 0; i < 5; i++) begin
         e0 = en_count;
         do_req(0, t_f3[i], 24'h10, 32'd0);
         chk("load_rdata", got_rdata, t_exp[i]);
         chk("load_latency", 32'(got_resp_cyc - acc_cyc), 32'd6);
         chk("load_en_pulses", 32'(en_count - e0), 32'd1);
      end

      // store then load back
      do_req(1, 3'b010, 24'h0c, 32'h01020304);
      chk("sw_rdata_zero", got_rdata, 32'd0);
      do_req(0, 3'b010, 24'h0c, 32'd0);
      chk("lw_after_sw", got_rdata, 32'h01020304);
      do_req(1, 3'b000, 24'h0d, 32'h000000ff);
      do_req(0, 3'b010, 24'h0c, 32'd0);
      chk("lw_after_sb", got_rdata, 32'h0102ff04);

      // silent controller -> watchdog
      stub_mute = 1;
      do_req(0, 3'b010, 24'h10, 32'd0);
      stub_mute = 0;
      chk("timeout_flag", 32'(got_timeout), 32'd1);
      chk("timeout_rdata", got_rdata, 32'd0);
      chk("timeout_latency", 32'(got_resp_cyc - acc_cyc), 32'd16);

      // reset while waiting, late controller answer must be ignored
      r0 = resp_count;
      @(negedge clk);
      core.req_valid = 1; core.req_we = 0; core.req_funct3 = 3'b010; core.req_addr = 24'h10;
      n0 = n_acc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (n_acc != n0) break;
      end
      core.req_valid = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk_reset_state("midreset");
      repeat (8) @(negedge clk);
      chk("midreset_no_resp", 32'(resp_count - r0), 32'd0);
      do_req(0, 3'b010, 24'h10, 32'd0);
      chk("post_reset_lw", got_rdata, 32'hddccbbaa);

      // misaligned word load
      e0 = en_count;
      do_req(0, 3'b010, 24'h11, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misalign_err", 32'(got_err), 32'd1);
      chk("misalign_no_enable", 32'(en_count - e0), 32'd0);
      chk("misalign_latency", 32'(got_resp_cyc - acc_cyc), 32'd0);
      chk("misalign_rdata", got_rdata, 32'd0);
`else
      chk("misalign_err", 32'(got_err), 32'd0);
      chk("misalign_addr", 32'(got_addr), 32'h11);
      chk("misalign_enable", 32'(en_count - e0), 32'd1);
      chk("misalign_rdata", got_rdata, 32'hefddccbb);
`endif

      // request held high: one accept per IDLE visit
      e0 = en_count; r0 = resp_count;
      @(negedge clk);
      core.req_valid = 1; core.req_we = 0; core.req_funct3 = 3'b010; core.req_addr = 24'h10;
      repeat (14) @(negedge clk);
      core.req_valid = 0;
      wait_done();
      chk("held_enables", 32'(en_count - e0), 32'd2);
      chk("held_resps", 32'(resp_count - r0), 32'd2);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                ADDR_W'(32'h20 + $urandom_range(0, 31)), $urandom);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and memory_controller_module.
- Accepts one load/store request per transaction using RV32 funct3 encoding, and drives the controller's enable, address, write-enable, mode and write-data inputs.
- Waits for op_r, then captures data_out and applies RV32 sign/zero extension, since the controller only zero-extends.
- Returns a single-cycle response to the core; a watchdog bounds the wait.

Parameters:
ADDR_W, 24, byte address width, matching the controller address bus
TIMEOUT_CYCLES, 15, maximum cycles spent in WAIT before a timeout response

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  core request strobe
req_ready  out  1  high in IDLE only; request accepted on the edge where req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign field
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores, timeouts and errors
resp_timeout  out  1  qualifies resp_valid: controller did not answer
resp_err  out  1  qualifies resp_valid: misaligned access (see Optional Feature)
mem_enable  out  1  one-cycle start pulse to controller
mem_addr  out  ADDR_W  latched address
mem_we  out  1  latched write enable
mem_wdata  out  32  latched store data
mem_instr_mode  out  2  00 word, 01 byte, 10 half
mem_data_out  in  32  controller read data
mem_op_r  in  1  controller ready pulse

Behaviour:
- Reset: state=IDLE; req_ready=1. resp_valid, resp_timeout, resp_err and mem_enable are 0. resp_rdata, mem_addr, mem_wdata, mem_we and mem_instr_mode are all 0.
- Reset mid-operation returns the block to IDLE immediately. The controller may still complete its cycle; any mem_op_r seen outside WAIT is ignored.
- IDLE: on accept, latch addr/we/wdata/funct3. Go to ISSUE (or to RESP when a misaligned trap applies).
- ISSUE: mem_enable=1 for exactly one cycle, watchdog cleared; next state is WAIT.
- WAIT:
  - If mem_op_r=1: capture mem_data_out, extend it, go to RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: set resp_timeout, go to RESP.
  - Else: watchdog +1.
- RESP: resp_valid=1 for one cycle with its qualifiers, then back to IDLE. resp_rdata holds its value until the next response.
- Mode mapping:
  - funct3 000/100 → mode 01 (byte).
  - funct3 001/101 → mode 10 (half).
  - funct3 010 → mode 00 (word).
  - funct3 011/110/111 are decoded as word; store funct3[2] is ignored.
- Extension:
  - lb: sign of bit 7.
  - lbu: zero-extend from bit 7.
  - lh: sign of bit 15.
  - lhu: zero-extend from bit 15.
  - lw: passthrough.
- Stores: resp_rdata=0; mem_data_out is not sampled.
- Latency with the current controller: resp_valid is asserted 6 edges after the accept edge. Throughput is one transaction per 7 cycles. There are no back-to-back requests while busy.
- Simultaneous mem_op_r and watchdog expiry: mem_op_r wins and resp_timeout=0.
- Watchdog width is clog2(TIMEOUT_CYCLES)+1 bits, saturating.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: an accepted halfword request with addr[0]!=0, or word request with addr[1:0]!=0, goes IDLE→RESP. resp_valid appears on the next cycle with resp_err=1 and resp_rdata=0; mem_enable is never asserted.
- Undefined: resp_err is tied to 0 and every request is issued unchanged.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - controller mode constants (MODE_WORD=00, MODE_BYTE=01, MODE_HALF=10);
  - the state encoding (IDLE, ISSUE, WAIT, RESP).
- One combinational sub-module, load_extend (inputs funct3 and raw data, output extended word), instantiated once.

Test Plan:
- Bytes aa,bb,cc,dd preloaded at 0x10:
  - lw 0x10 → 0xddccbbaa
  - lb → 0xffffffaa
  - lbu → 0x000000aa
  - lh → 0xffffbbaa
  - lhu → 0x0000bbaa
  - Each has resp_valid exactly 6 edges after accept and mem_enable high for exactly 1 cycle.
- sw 0x01020304 at 0x0c, then lw 0x0c → 0x01020304. Then sb 0x000000ff at 0x0d, then lw 0x0c → 0x0102ff04.
- Controller stubbed with mem_op_r held 0 → resp_valid with resp_timeout=1 and rdata=0 after TIMEOUT_CYCLES cycles in WAIT; req_ready returns on the following cycle.
- rst asserted during WAIT, then the controller's late mem_op_r arrives → no resp_valid, state stays IDLE, and the next lw completes normally.
- With LSU_MISALIGN_TRAP_EN: lw 0x11 → resp_err=1 on the cycle after accept, no mem_enable. Without the macro: the same request is issued with mem_addr=0x11 and resp_err=0.
- req_valid held high through a transaction → exactly one accept per IDLE visit; req_ready=0 in ISSUE, WAIT and RESP.
